// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, optional two-entry skid buffer,
// flush with PC retention and a saturating bubble counter. Bubbles carry an all-zero
// payload so downstream stages see a nop.
module pipe_stage_reg #(
    parameter int unsigned     DATA_W           = 128,
    parameter int unsigned     PC_W             = 32,
    parameter bit              SKID             = 1'b1,
    parameter bit              KEEP_PC_ON_FLUSH = 1'b1,
    parameter logic [PC_W-1:0] RESET_PC         = PC_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt
);

    // Main entry drives the outputs; skid entry only ever holds data when main is full.
    logic              r_main_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;
    logic [15:0]       r_bubble_cnt;

    logic              w_main_valid_d;
    logic [PC_W-1:0]   w_main_pc_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic              w_skid_valid_d;
    logic [PC_W-1:0]   w_skid_pc_d;
    logic [DATA_W-1:0] w_skid_data_d;
    logic [15:0]       w_bubble_cnt_d;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    // With a skid entry, in_ready is a pure register output so it never depends on out_ready.
    assign w_in_ready = SKID ? !r_skid_valid : (!r_main_valid || out_ready);
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    // Next-state for main/skid entries and the bubble counter.
    always_comb begin
        w_main_valid_d = r_main_valid;
        w_main_pc_d    = r_main_pc;
        w_main_data_d  = r_main_data;
        w_skid_valid_d = r_skid_valid;
        w_skid_pc_d    = r_skid_pc;
        w_skid_data_d  = r_skid_data;

        if (SKID) begin
            if (!r_main_valid || w_out_fire) begin
                if (r_skid_valid) begin
                    w_main_valid_d = 1'b1;
                    w_main_pc_d    = r_skid_pc;
                    w_main_data_d  = r_skid_data;
                end else if (w_in_fire) begin
                    w_main_valid_d = 1'b1;
                    w_main_pc_d    = in_pc;
                    w_main_data_d  = in_data;
                end else begin
                    w_main_valid_d = 1'b0;
                    w_main_data_d  = '0;
                end
                // Skid refills only if it just drained into main while an input was taken.
                if (r_skid_valid && w_in_fire) begin
                    w_skid_valid_d = 1'b1;
                    w_skid_pc_d    = in_pc;
                    w_skid_data_d  = in_data;
                end else begin
                    w_skid_valid_d = 1'b0;
                    w_skid_data_d  = '0;
                end
            end else if (w_in_fire) begin
                w_skid_valid_d = 1'b1;
                w_skid_pc_d    = in_pc;
                w_skid_data_d  = in_data;
            end
        end else begin
            if (w_in_fire) begin
                w_main_valid_d = 1'b1;
                w_main_pc_d    = in_pc;
                w_main_data_d  = in_data;
            end else if (w_out_fire) begin
                w_main_valid_d = 1'b0;
                w_main_data_d  = '0;
            end
        end

        // Flush squashes everything, including the input offered this cycle.
        if (flush) begin
            w_main_valid_d = 1'b0;
            w_main_data_d  = '0;
            w_main_pc_d    = KEEP_PC_ON_FLUSH ? in_pc : RESET_PC;
            w_skid_valid_d = 1'b0;
            w_skid_data_d  = '0;
        end

        w_bubble_cnt_d = r_bubble_cnt;
        if (!r_main_valid && (r_bubble_cnt != 16'hFFFF)) begin
            w_bubble_cnt_d = r_bubble_cnt + 16'd1;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= RESET_PC;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= RESET_PC;
            r_skid_data  <= '0;
            r_bubble_cnt <= 16'd0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_main_pc    <= w_main_pc_d;
            r_main_data  <= w_main_data_d;
            r_skid_valid <= w_skid_valid_d;
            r_skid_pc    <= w_skid_pc_d;
            r_skid_data  <= w_skid_data_d;
            r_bubble_cnt <= w_bubble_cnt_d;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_main_valid;
    assign out_pc     = r_main_pc;
    assign out_data   = r_main_data;
    assign bubble_cnt = r_bubble_cnt;

endmodule
